axis_byte_serializer: RTL and testbench
=======================================

# axis_byte_serializer

Downstream neighbour of the AXI-Stream processor wrapper. Accepts one byte-aligned output word per handshake on a slave AXI-Stream port and emits it as a sequence of 8-bit beats on a master AXI-Stream port, with `m_axis_tlast` marking the final byte of each word. It feeds the byte-oriented host transmit path (UART/FIFO), so processor output words leave the FPGA without width glue. A one-word skid register keeps `s_axis_tready` registered and allows back-to-back words with no idle cycle.

## Interface
- `WORD_WIDTH`, default 16: input word width in bits; must be a nonzero multiple of 8, otherwise elaboration stops with `$error`. `NB = WORD_WIDTH/8` is derived.
- `MSB_FIRST`, default 1: 1 sends the most significant byte first; 0 sends the least significant byte first.
- `clk` in 1: single clock; all state is updated on its rising edge.
- `arst` in 1: reset; asynchronous, active-high.
- `s_axis_tdata` in WORD_WIDTH: input word.
- `s_axis_tvalid` in 1: input word valid.
- `s_axis_tready` out 1: block can accept a word.
- `m_axis_tdata` out 8: current byte.
- `m_axis_tvalid` out 1: byte valid.
- `m_axis_tready` in 1: downstream accepts the byte.
- `m_axis_tlast` out 1: high on the last byte of a word.

## Operation
- The block holds four registers:
  - `shreg`, WORD_WIDTH bits: word currently being sent.
  - `cnt`, range 0..NB: bytes remaining in `shreg`.
  - `skid`, WORD_WIDTH bits: waiting word.
  - `skid_full`: flag for `skid`.
- Handshake definitions:
  - In-handshake: `s_axis_tvalid && s_axis_tready`.
  - Out-handshake: `m_axis_tvalid && m_axis_tready`.
- Output assignments:
  - `m_axis_tvalid = (cnt != 0)`.
  - `m_axis_tlast = (cnt == 1)`.
  - `m_axis_tdata` is the top byte of `shreg` if MSB_FIRST=1, else the bottom byte.
- `s_axis_tready = !skid_full`. It is driven from a register only; there is no combinational path from `m_axis_tready`.
- `free` is true this cycle when `cnt == 0`, or when `cnt == 1` and an out-handshake occurs.
- On an out-handshake with `cnt > 1`: `shreg` shifts one byte toward the output end (left if MSB_FIRST=1, else right). Vacated bits fill with 0. `cnt` decrements.
- When `free` is true:
  - If `skid_full`: load `shreg <= skid`, `cnt <= NB`, `skid_full <= 0`. No in-handshake can occur in this cycle.
  - Else, if an in-handshake occurs: load `shreg <= s_axis_tdata`, `cnt <= NB`.
  - Else: `cnt <= 0`.
- When `free` is false and an in-handshake occurs: `skid <= s_axis_tdata`, `skid_full <= 1`.
- Data is never dropped or duplicated. Bytes go out in word order, then byte order.
- The block does not inspect word contents; an all-zero word is sent as NB zero bytes.

## Timing
- Reset (`arst` high, asynchronous):
  - `cnt = 0`, `skid_full = 0`, `shreg = 0`, `skid = 0`.
  - Outputs: `m_axis_tvalid = 0`, `m_axis_tlast = 0`, `m_axis_tdata = 0`.
  - `s_axis_tready` is forced 0 while `arst` is high and is 1 in the first cycle after release.
- Reset mid-word: the remaining bytes and any skid word are discarded. No `m_axis_tlast` is emitted for the truncated word.
- Latency: a word accepted at edge N presents its first byte with `m_axis_tvalid = 1` from just after edge N.
- Throughput: NB cycles per word with `m_axis_tready` held high. Consecutive words have no bubble, because the skid or direct load coincides with the last byte's handshake.
- Backpressure:
  - `m_axis_tdata`, `m_axis_tlast` and `m_axis_tvalid` stay stable while `m_axis_tvalid && !m_axis_tready`.
  - Once `skid_full` is set, `s_axis_tready` is 0 until the cycle after the skid word moves into `shreg`.
- NB = 1 (WORD_WIDTH = 8): every byte has `m_axis_tlast = 1`. Sustained rate is one word per cycle.
- Simultaneous last-byte out-handshake and in-handshake with the skid empty: the input word loads directly into `shreg` and the skid is not used.

## Test plan
- **Basic MSB-first:** WORD_WIDTH=24, MSB_FIRST=1. Send word 0xA1B2C3 with `m_axis_tready` = 1. Required output: bytes A1, B2, C3 on three consecutive cycles, with `m_axis_tlast` high only on C3. `s_axis_tready` is never 0.
- **LSB-first:** MSB_FIRST=0, same word. Required output: C3, B2, A1, with `m_axis_tlast` on A1.
- **Back-to-back:** send 0x1122 then 0x3344 (WORD_WIDTH=16) with `s_axis_tvalid` held high. Required output: 11, 22, 33, 44 on four consecutive cycles. Two extra words are held back by `s_axis_tready` = 0 while the skid is full.
- **Random backpressure:** toggle `m_axis_tready` on a random pattern over 1000 random words. The scoreboard requires exact byte order, `m_axis_tlast` every NB bytes, and stable outputs while stalled.
- **Reset mid-word:** assert `arst` for 1 cycle after byte 0x11 of 0x1122 is taken, with 0x3344 in the skid. Required: all outputs 0 during reset, no further bytes until a new word arrives, then 0x5566 is sent as 55, 66.
- **Single-byte words:** WORD_WIDTH=8. A stream of 0x00..0x0F with `m_axis_tready` high gives one byte per cycle, each with `m_axis_tlast` = 1.

Source files
------------

// File: rtl/axis_byte_serializer.sv
// axis_byte_serializer
//   Splits each WORD_WIDTH-bit word received on a slave AXI-Stream port into
//   NB = WORD_WIDTH/8 byte beats on a master AXI-Stream port. m_axis_tlast
//   marks the final byte of each word. A one-word skid register keeps
//   s_axis_tready registered and lets words follow each other without a gap.
//
// Parameters
//   WORD_WIDTH : input word width, nonzero multiple of 8
//   MSB_FIRST  : 1 = most significant byte first, 0 = least significant first
//
// Ports
//   clk            : clock, all state changes on its rising edge
//   arst           : asynchronous active-high reset
//   s_axis_tdata   : input word
//   s_axis_tvalid  : input word valid
//   s_axis_tready  : block can accept a word (registered)
//   m_axis_tdata   : current output byte
//   m_axis_tvalid  : output byte valid
//   m_axis_tready  : downstream accepts the byte
//   m_axis_tlast   : last byte of the current word
module axis_byte_serializer #(
  parameter int WORD_WIDTH = 16,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [WORD_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [7:0]            m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int NB = WORD_WIDTH / 8;
  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NB);

  if ((WORD_WIDTH % 8) != 0 || WORD_WIDTH <= 0) begin : g_bad_width
    $error("axis_byte_serializer: WORD_WIDTH must be a nonzero multiple of 8");
  end

  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [WORD_WIDTH-1:0] skid_q, skid_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  skid_full_q, skid_full_d;

  logic in_hs;
  logic out_hs;
  logic free;

  // Gating with arst keeps tready low during reset while still letting it
  // rise in the very first cycle after release; nothing from the master side
  // reaches it.
  assign s_axis_tready = ~skid_full_q & ~arst;
  assign m_axis_tvalid = (cnt_q != CNT_ZERO);
  assign m_axis_tlast  = (cnt_q == CNT_ONE);

  if (MSB_FIRST) begin : g_msb
    assign m_axis_tdata = shreg_q[WORD_WIDTH-1 -: 8];
  end else begin : g_lsb
    assign m_axis_tdata = shreg_q[7:0];
  end

  assign in_hs  = s_axis_tvalid & s_axis_tready;
  assign out_hs = m_axis_tvalid & m_axis_tready;
  // shreg can take a new word now: empty, or its last byte leaves this cycle.
  assign free   = (cnt_q == CNT_ZERO) | ((cnt_q == CNT_ONE) & out_hs);

  always_comb begin
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;

    if (free) begin
      // With the skid full, s_axis_tready is low, so no input can collide.
      if (skid_full_q) begin
        shreg_d     = skid_q;
        cnt_d       = CNT_FULL;
        skid_full_d = 1'b0;
      end else if (in_hs) begin
        shreg_d = s_axis_tdata;
        cnt_d   = CNT_FULL;
      end else begin
        cnt_d = CNT_ZERO;
      end
    end else begin
      if (out_hs) begin
        if (MSB_FIRST) begin
          shreg_d = shreg_q << 8;
        end else begin
          shreg_d = shreg_q >> 8;
        end
        cnt_d = cnt_q - CNT_ONE;
      end
      if (in_hs) begin
        skid_d      = s_axis_tdata;
        skid_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      shreg_q     <= '0;
      skid_q      <= '0;
      cnt_q       <= CNT_ZERO;
      skid_full_q <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      skid_q      <= skid_d;
      cnt_q       <= cnt_d;
      skid_full_q <= skid_full_d;
    end
  end

endmodule

// File: tb/tb_axis_byte_serializer.sv
module tb_axis_byte_serializer;

  logic clk;
  logic arst;

  // 16-bit MSB-first instance
  logic [15:0] s16_data;
  logic        s16_valid, s16_ready;
  logic [7:0]  m16_data;
  logic        m16_valid, m16_ready, m16_last;

  // 24-bit MSB-first and LSB-first instances share their inputs
  logic [23:0] s24_data;
  logic        s24_valid, m24_ready;
  logic        s24m_ready, s24l_ready;
  logic [7:0]  m24m_data, m24l_data;
  logic        m24m_valid, m24l_valid, m24m_last, m24l_last;

  // 8-bit instance
  logic [7:0]  s8_data;
  logic        s8_valid, s8_ready;
  logic [7:0]  m8_data;
  logic        m8_valid, m8_ready, m8_last;

  int total = 0;
  int bad   = 0;

  axis_byte_serializer #(.WORD_WIDTH(16), .MSB_FIRST(1'b1)) u16 (
    .clk(clk), .arst(arst),
    .s_axis_tdata(s16_data), .s_axis_tvalid(s16_valid), .s_axis_tready(s16_ready),
    .m_axis_tdata(m16_data), .m_axis_tvalid(m16_valid), .m_axis_tready(m16_ready),
    .m_axis_tlast(m16_last));

  axis_byte_serializer #(.WORD_WIDTH(24), .MSB_FIRST(1'b1)) u24m (
    .clk(clk), .arst(arst),
    .s_axis_tdata(s24_data), .s_axis_tvalid(s24_valid), .s_axis_tready(s24m_ready),
    .m_axis_tdata(m24m_data), .m_axis_tvalid(m24m_valid), .m_axis_tready(m24_ready),
    .m_axis_tlast(m24m_last));

  axis_byte_serializer #(.WORD_WIDTH(24), .MSB_FIRST(1'b0)) u24l (
    .clk(clk), .arst(arst),
    .s_axis_tdata(s24_data), .s_axis_tvalid(s24_valid), .s_axis_tready(s24l_ready),
    .m_axis_tdata(m24l_data), .m_axis_tvalid(m24l_valid), .m_axis_tready(m24_ready),
    .m_axis_tlast(m24l_last));

  axis_byte_serializer #(.WORD_WIDTH(8), .MSB_FIRST(1'b1)) u8 (
    .clk(clk), .arst(arst),
    .s_axis_tdata(s8_data), .s_axis_tvalid(s8_valid), .s_axis_tready(s8_ready),
    .m_axis_tdata(m8_data), .m_axis_tvalid(m8_valid), .m_axis_tready(m8_ready),
    .m_axis_tlast(m8_last));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  em [3];
    logic [7:0]  el [3];
    logic [15:0] w16 [4];
    logic [7:0]  eb16 [8];
    logic        erdy [8];
    logic [8:0]  q [$];
    int          wi;
    int          words_in;
    int          words_out;
    logic        exp_rdy;
    logic [8:0]  front;

    arst = 1'b1;
    s16_data = '0; s16_valid = 0; m16_ready = 1;
    s24_data = '0; s24_valid = 0; m24_ready = 1;
    s8_data  = '0; s8_valid  = 0; m8_ready  = 1;

    // reset state
    @(negedge clk);
    chk("rst_rdy16", {31'd0, s16_ready}, 0);
    chk("rst_val16", {31'd0, m16_valid}, 0);
    chk("rst_last16", {31'd0, m16_last}, 0);
    chk("rst_data16", {24'd0, m16_data}, 0);
    chk("rst_rdy24", {30'd0, s24m_ready, s24l_ready}, 0);
    chk("rst_out24", {14'd0, m24m_valid, m24l_valid, m24m_data, m24l_data}, 0);
    chk("rst_rdy8", {31'd0, s8_ready}, 0);
    tick();
    arst = 1'b0;
    @(negedge clk);
    chk("post_rst_rdy", {28'd0, s16_ready, s24m_ready, s24l_ready, s8_ready}, 4'hF);
    tick();

    // 24-bit word, both byte orders
    em[0] = 8'hA1; em[1] = 8'hB2; em[2] = 8'hC3;
    el[0] = 8'hC3; el[1] = 8'hB2; el[2] = 8'hA1;
    for (int c = 0; c < 5; c++) begin
      s24_valid = (c == 0);
      s24_data  = 24'hA1B2C3;
      @(negedge clk);
      chk("b24_rdy", {30'd0, s24m_ready, s24l_ready}, 2'b11);
      if (c >= 1 && c <= 3) begin
        chk("b24m_val", {31'd0, m24m_valid}, 1);
        chk("b24m_data", {24'd0, m24m_data}, {24'd0, em[c-1]});
        chk("b24m_last", {31'd0, m24m_last}, (c == 3) ? 1 : 0);
        chk("b24l_val", {31'd0, m24l_valid}, 1);
        chk("b24l_data", {24'd0, m24l_data}, {24'd0, el[c-1]});
        chk("b24l_last", {31'd0, m24l_last}, (c == 3) ? 1 : 0);
      end else begin
        chk("b24_idle", {30'd0, m24m_valid, m24l_valid}, 0);
      end
      tick();
    end
    s24_valid = 0;

    // back-to-back 16-bit words held by the skid
    w16[0] = 16'h1122; w16[1] = 16'h3344; w16[2] = 16'h5566; w16[3] = 16'h7788;
    for (int i = 0; i < 8; i++) eb16[i] = 8'h11 * (i + 1);
    erdy[0] = 1; erdy[1] = 1; erdy[2] = 0; erdy[3] = 1;
    erdy[4] = 0; erdy[5] = 1; erdy[6] = 0; erdy[7] = 1;
    wi = 0;
    for (int c = 0; c < 10; c++) begin
      s16_valid = (wi < 4);
      s16_data  = (wi < 4) ? w16[wi] : 16'h0;
      @(negedge clk);
      if (c < 8) chk("b2b_rdy", {31'd0, s16_ready}, {31'd0, erdy[c]});
      if (c >= 1 && c <= 8) begin
        chk("b2b_val", {31'd0, m16_valid}, 1);
        chk("b2b_data", {24'd0, m16_data}, {24'd0, eb16[c-1]});
        chk("b2b_last", {31'd0, m16_last}, (c % 2 == 0) ? 1 : 0);
      end else begin
        chk("b2b_idle", {31'd0, m16_valid}, (c == 0) ? 0 : 0);
      end
      if (s16_valid && s16_ready) wi++;
      tick();
    end
    s16_valid = 0;

    // reset mid-word with a word waiting in the skid
    s16_valid = 1; s16_data = 16'h1122;
    @(negedge clk);
    chk("mid_acc0", {31'd0, s16_ready}, 1);
    tick();
    s16_data = 16'h3344;
    @(negedge clk);
    chk("mid_b11", {23'd0, m16_valid, m16_data}, {23'd0, 1'b1, 8'h11});
    chk("mid_acc1", {31'd0, s16_ready}, 1);
    tick();
    arst = 1'b1;
    s16_valid = 0;
    @(negedge clk);
    chk("mid_rst_out", {21'd0, s16_ready, m16_valid, m16_last, m16_data}, 0);
    tick();
    arst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("mid_quiet", {30'd0, m16_valid, m16_last}, 0);
      chk("mid_rdy", {31'd0, s16_ready}, 1);
      tick();
    end
    s16_valid = 1; s16_data = 16'h5566;
    @(negedge clk);
    tick();
    s16_valid = 0;
    @(negedge clk);
    chk("mid_b55", {22'd0, m16_valid, m16_last, m16_data}, {22'd0, 2'b10, 8'h55});
    tick();
    @(negedge clk);
    chk("mid_b66", {22'd0, m16_valid, m16_last, m16_data}, {22'd0, 2'b11, 8'h66});
    tick();
    @(negedge clk);
    chk("mid_end", {31'd0, m16_valid}, 0);
    tick();

    // single-byte words, one per cycle
    for (int c = 0; c < 18; c++) begin
      s8_valid = (c < 16);
      s8_data  = 8'(c);
      @(negedge clk);
      if (c < 16) chk("sb_rdy", {31'd0, s8_ready}, 1);
      if (c >= 1 && c <= 16) begin
        chk("sb_out", {22'd0, m8_valid, m8_last, m8_data}, {22'd0, 2'b11, 8'(c - 1)});
      end else begin
        chk("sb_idle", {31'd0, m8_valid}, (c == 0) ? 0 : 0);
      end
      tick();
    end
    s8_valid = 0;

    // random traffic and backpressure against a byte-queue model
    words_in = 0;
    words_out = 0;
    for (int cyc = 0; cyc < 30000 && words_out < 1000; cyc++) begin
      s16_valid = (words_in < 1000) && ($urandom_range(0, 3) != 0);
      s16_data  = 16'($urandom);
      m16_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      // skid is occupied exactly when more than one word's worth of bytes waits
      exp_rdy = (q.size() <= 2);
      chk("rnd_rdy", {31'd0, s16_ready}, {31'd0, exp_rdy});
      chk("rnd_val", {31'd0, m16_valid}, (q.size() != 0) ? 1 : 0);
      if (q.size() != 0) begin
        front = q[0];
        chk("rnd_data", {23'd0, m16_last, m16_data}, {23'd0, front});
      end
      if (m16_valid && m16_ready && q.size() != 0) begin
        front = q.pop_front();
        if (front[8]) words_out++;
      end
      if (s16_valid && exp_rdy) begin
        q.push_back({1'b0, s16_data[15:8]});
        q.push_back({1'b1, s16_data[7:0]});
        words_in++;
      end
      tick();
    end
    m16_ready = 1;
    s16_valid = 0;
    chk("rnd_words", words_out, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
